// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared constants and helpers for the BRAM port arbiter
package bram_arb_pkg;

  localparam logic READ  = 1'b0;
  localparam logic WRITE = 1'b1;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W  = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/bram_rr_pick.sv
// rtl/bram_rr_pick.sv - rotating-priority finder: first set mask bit at or after start
module bram_rr_pick
  import bram_arb_pkg::*;
#(
  parameter int N   = DEF_N_REQ,
  parameter int IDW = clog2(DEF_N_REQ)
) (
  input  logic [N-1:0]   i_mask,
  input  logic [IDW-1:0] i_start,
  output logic           o_found,
  output logic [IDW-1:0] o_idx
);

  // Walk from the farthest offset back to the start so the nearest hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_mask[(int'(i_start) + k) % N]) begin
        o_found = 1'b1;
        o_idx   = IDW'((int'(i_start) + k) % N);
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - shares both ports of a true-dual-port BRAM among N_REQ requesters
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int N_REQ  = DEF_N_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ-1:0]         req_we,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  input  logic [N_REQ*DATA_W-1:0]  req_wdata,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_REQ-1:0]         rsp_valid,
  output logic [N_REQ*DATA_W-1:0]  rsp_data,
  output logic [CNT_W-1:0]         conflict_cnt,
  output logic                     wr_ena,
  output logic                     rd_ena,
  output logic                     wr_enb,
  output logic                     rd_enb,
  output logic [ADDR_W-1:0]        addra,
  output logic [ADDR_W-1:0]        addrb,
  output logic [DATA_W-1:0]        dina,
  output logic [DATA_W-1:0]        dinb,
  input  logic [DATA_W-1:0]        douta,
  input  logic [DATA_W-1:0]        doutb
);

  localparam int IDW   = clog2(N_REQ);
  localparam int SUM_W = CNT_W + 4;

  logic [IDW-1:0]          r_ptr;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_tag_a_v, r_tag_b_v;
  logic [IDW-1:0]          r_tag_a_id, r_tag_b_id;
  logic [N_REQ-1:0]        r_rsp_valid;
  logic [N_REQ*DATA_W-1:0] r_rsp_data;

  logic                    w_found_a, w_found_b;
  logic [IDW-1:0]          w_idx_a, w_idx_b, w_start_b, w_next_ptr;
  logic [N_REQ-1:0]        w_conflict, w_mask_b;
  logic                    w_we_a, w_we_b, w_gnt_a, w_gnt_b;
  logic [ADDR_W-1:0]       w_addr_a, w_addr_b;
  logic [3:0]              w_nconf;
  logic [SUM_W-1:0]        w_sum;

  bram_rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick_a (
    .i_mask  (req_valid),
    .i_start (r_ptr),
    .o_found (w_found_a),
    .o_idx   (w_idx_a)
  );

  assign w_we_a    = req_we[w_idx_a];
  assign w_addr_a  = req_addr[int'(w_idx_a)*ADDR_W +: ADDR_W];
  assign w_start_b = (w_idx_a == IDW'(N_REQ - 1)) ? '0 : w_idx_a + 1'b1;

  // Anything that would touch A's address with a write on either side is deferred.
  always_comb begin
    w_conflict = '0;
    w_nconf    = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_found_a && req_valid[i] && (IDW'(i) != w_idx_a) &&
          (req_addr[i*ADDR_W +: ADDR_W] == w_addr_a) &&
          ((w_we_a == WRITE) || (req_we[i] == WRITE))) begin
        w_conflict[i] = 1'b1;
        w_nconf       = w_nconf + 4'd1;
      end
    end
  end

  always_comb begin
    w_mask_b = req_valid & ~w_conflict;
    if (w_found_a) w_mask_b[w_idx_a] = 1'b0;
  end

  bram_rr_pick #(.N(N_REQ), .IDW(IDW)) u_pick_b (
    .i_mask  (w_mask_b),
    .i_start (w_start_b),
    .o_found (w_found_b),
    .o_idx   (w_idx_b)
  );

  assign w_we_b   = req_we[w_idx_b];
  assign w_addr_b = req_addr[int'(w_idx_b)*ADDR_W +: ADDR_W];
  assign w_gnt_a  = en && w_found_a;
  assign w_gnt_b  = en && w_found_b;

  always_comb begin
    req_ready = '0;
    if (w_gnt_a) req_ready[w_idx_a] = 1'b1;
    if (w_gnt_b) req_ready[w_idx_b] = 1'b1;
  end

  assign wr_ena = w_gnt_a && (w_we_a == WRITE);
  assign rd_ena = w_gnt_a && (w_we_a == READ);
  assign wr_enb = w_gnt_b && (w_we_b == WRITE);
  assign rd_enb = w_gnt_b && (w_we_b == READ);
  assign addra  = w_gnt_a ? w_addr_a : '0;
  assign addrb  = w_gnt_b ? w_addr_b : '0;
  assign dina   = w_gnt_a ? req_wdata[int'(w_idx_a)*DATA_W +: DATA_W] : '0;
  assign dinb   = w_gnt_b ? req_wdata[int'(w_idx_b)*DATA_W +: DATA_W] : '0;

  always_comb begin
    w_next_ptr = w_gnt_b ? w_idx_b : w_idx_a;
    w_next_ptr = (w_next_ptr == IDW'(N_REQ - 1)) ? '0 : w_next_ptr + 1'b1;
  end

  assign w_sum = SUM_W'(r_cnt) + SUM_W'(w_nconf);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_tag_a_v   <= 1'b0;
      r_tag_b_v   <= 1'b0;
      r_tag_a_id  <= '0;
      r_tag_b_id  <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
    end else begin
      // Tags trail the BRAM's own output register by one stage.
      r_tag_a_v   <= w_gnt_a && (w_we_a == READ);
      r_tag_b_v   <= w_gnt_b && (w_we_b == READ);
      r_tag_a_id  <= w_idx_a;
      r_tag_b_id  <= w_idx_b;
      r_rsp_valid <= '0;
      if (r_tag_a_v) begin
        r_rsp_valid[r_tag_a_id]                       <= 1'b1;
        r_rsp_data[int'(r_tag_a_id)*DATA_W +: DATA_W] <= douta;
      end
      if (r_tag_b_v) begin
        r_rsp_valid[r_tag_b_id]                       <= 1'b1;
        r_rsp_data[int'(r_tag_b_id)*DATA_W +: DATA_W] <= doutb;
      end
      if (w_gnt_a) r_ptr <= w_next_ptr;
      if (en) begin
        if (w_sum > SUM_W'({CNT_W{1'b1}})) r_cnt <= '1;
        else                               r_cnt <= w_sum[CNT_W-1:0];
      end
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - directed scoreboard bench for bram_port_arbiter with a BRAM model
module tb_bram_port_arbiter;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  logic        clk, rst, en;
  logic [3:0]  req_valid, req_we, req_ready, rsp_valid;
  logic [39:0] req_addr;
  logic [63:0] req_wdata, rsp_data;
  logic [1:0]  conflict_cnt;
  logic        wr_ena, rd_ena, wr_enb, rd_enb;
  logic [9:0]  addra, addrb;
  logic [15:0] dina, dinb, douta, doutb;
  logic [15:0] mem [0:1023];

  typedef struct {
    int          due;
    int          id;
    logic [15:0] data;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  bram_port_arbiter #(.N_REQ(4), .ADDR_W(10), .DATA_W(16), .CNT_W(2)) u_dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .conflict_cnt(conflict_cnt),
    .wr_ena(wr_ena), .rd_ena(rd_ena), .wr_enb(wr_enb), .rd_enb(rd_enb),
    .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
    .douta(douta), .doutb(doutb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Registered-output true-dual-port BRAM
  always @(posedge clk) begin
    if (wr_ena) mem[addra] <= dina;
    if (wr_enb) mem[addrb] <= dinb;
    if (rd_ena) douta <= mem[addra];
    if (rd_enb) doutb <= mem[addrb];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_rsp(input int id, input logic [15:0] d);
    sb.push_back('{cyc + 2, id, d});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [9:0] a, input logic [15:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*10 +: 10]  = a;
    req_wdata[i*16 +: 16] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      look();
      tick();
    end
  endtask

  task automatic set_all_reads();
    set_req(0, RD, 10'h005, 16'h0);
    set_req(1, RD, 10'h006, 16'h0);
    set_req(2, RD, 10'h3A5, 16'h0);
    set_req(3, RD, 10'h100, 16'h0);
  endtask

  // Response monitor: every cycle, rsp_valid must equal exactly the responses due now.
  always @(negedge clk) begin
    logic [3:0]  ev;
    logic [15:0] ed [4];
    ev = '0;
    for (int k = 0; k < 4; k++) ed[k] = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        ev[sb[i].id] = 1'b1;
        ed[sb[i].id] = sb[i].data;
        sb.delete(i);
      end
    end
    check("rsp_valid", 64'(rsp_valid), 64'(ev));
    for (int k = 0; k < 4; k++)
      if (ev[k]) check($sformatf("rsp_data[%0d]", k), 64'(rsp_data[k*16 +: 16]), 64'(ed[k]));
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    look();
    check("reset_cnt", 64'(conflict_cnt), 64'd0);
    check("reset_ptr", 64'(u_dut.r_ptr), 64'd0);
    check("reset_rsp_data", rsp_data, 64'd0);
    tick();

    // Reset while a read is in flight: no response may appear.
    en = 1'b1;
    set_req(0, RD, 10'h010, 16'h0);
    look();
    check("midrst_ready", 64'(req_ready), 64'h1);
    tick();
    rst = 1'b1;
    clear_reqs();
    look();
    tick();
    rst = 1'b0;
    look();
    check("midrst_cnt", 64'(conflict_cnt), 64'd0);
    check("midrst_ptr", 64'(u_dut.r_ptr), 64'd0);
    tick();
    idle(3);

    // Preload through both ports as simultaneous writes.
    set_req(0, WR, 10'h005, 16'h1234);
    set_req(1, WR, 10'h006, 16'hBEEF);
    look();
    check("preload_ready", 64'(req_ready), 64'h3);
    check("preload_strobes", 64'({wr_ena, rd_ena, wr_enb, rd_enb}), 64'b1010);
    check("preload_addr", 64'({addra, addrb}), 64'({10'h005, 10'h006}));
    tick();
    clear_reqs();

    // Dual read.
    set_req(0, RD, 10'h005, 16'h0);
    set_req(1, RD, 10'h006, 16'h0);
    look();
    check("dual_ready", 64'(req_ready), 64'h3);
    check("dual_strobes", 64'({wr_ena, rd_ena, wr_enb, rd_enb}), 64'b0101);
    expect_rsp(0, 16'h1234);
    expect_rsp(1, 16'hBEEF);
    tick();
    clear_reqs();
    idle(3);

    // Write/read conflict on the same address.
    do_reset();
    set_req(0, WR, 10'h3A5, 16'h00FF);
    set_req(2, RD, 10'h3A5, 16'h0);
    look();
    check("wconf_ready", 64'(req_ready), 64'h1);
    check("wconf_strobes", 64'({wr_ena, rd_ena, wr_enb, rd_enb}), 64'b1000);
    tick();
    req_valid[0] = 1'b0;
    look();
    check("wconf_cnt", 64'(conflict_cnt), 64'd1);
    check("wconf_ready2", 64'(req_ready), 64'h4);
    expect_rsp(2, 16'h00FF);
    tick();
    clear_reqs();
    idle(3);

    // Same-address reads are granted together.
    set_req(0, WR, 10'h100, 16'h5A5A);
    look();
    check("same_pre_ready", 64'(req_ready), 64'h1);
    tick();
    clear_reqs();
    set_req(1, RD, 10'h100, 16'h0);
    set_req(3, RD, 10'h100, 16'h0);
    look();
    check("same_ready", 64'(req_ready), 64'hA);
    expect_rsp(1, 16'h5A5A);
    expect_rsp(3, 16'h5A5A);
    tick();
    clear_reqs();
    look();
    check("same_cnt", 64'(conflict_cnt), 64'd1);
    tick();
    idle(3);

    // Fairness: four steady readers alternate in pairs.
    do_reset();
    set_all_reads();
    for (int c = 0; c < 4; c++) begin
      look();
      if (c % 2 == 0) begin
        check("fair_ready", 64'(req_ready), 64'h3);
        expect_rsp(0, 16'h1234);
        expect_rsp(1, 16'hBEEF);
      end else begin
        check("fair_ready", 64'(req_ready), 64'hC);
        expect_rsp(2, 16'h00FF);
        expect_rsp(3, 16'h5A5A);
      end
      tick();
      check("fair_ptr", 64'(u_dut.r_ptr), (c % 2 == 0) ? 64'd2 : 64'd0);
    end
    clear_reqs();
    idle(3);

    // en=0 with a conflicting pair: no grants, no strobes, no counting.
    en = 1'b0;
    set_all_reads();
    set_req(0, WR, 10'h006, 16'hFFFF);
    look();
    check("en0_ready", 64'(req_ready), 64'h0);
    check("en0_strobes", 64'({wr_ena, rd_ena, wr_enb, rd_enb}), 64'b0000);
    tick();
    look();
    check("en0_cnt", 64'(conflict_cnt), 64'd0);
    check("en0_ptr", 64'(u_dut.r_ptr), 64'd0);
    tick();
    clear_reqs();
    en = 1'b1;

    // Counter saturation with a 2-bit counter.
    for (int c = 0; c < 5; c++) begin
      set_req(0, WR, 10'h200, 16'hC0DE);
      set_req(1, RD, 10'h200, 16'h0);
      look();
      if (c % 2 == 0) begin
        check("sat_ready", 64'(req_ready), 64'h1);
      end else begin
        check("sat_ready", 64'(req_ready), 64'h2);
        expect_rsp(1, 16'hC0DE);
      end
      tick();
      check("sat_cnt", 64'(conflict_cnt), (c >= 2) ? 64'd3 : 64'(c + 1));
    end
    clear_reqs();
    check("sat_ptr", 64'(u_dut.r_ptr), 64'd1);

    // One grant cycle, then en drops while the reads are still in flight.
    set_all_reads();
    look();
    check("midstream_ready", 64'(req_ready), 64'h6);
    expect_rsp(1, 16'hBEEF);
    expect_rsp(2, 16'h00FF);
    tick();
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      look();
      check("midstream_off_ready", 64'(req_ready), 64'h0);
      check("midstream_off_strobes", 64'({wr_ena, rd_ena, wr_enb, rd_enb}), 64'b0000);
      tick();
    end
    clear_reqs();
    idle(2);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
